// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// - state_t             : main control FSM states
// - OP_*                : instr[6:0] opcodes the controller recognises
// - ALUOP_*/SRCA_*/...  : select encodings driven onto the datapath muxes
// - alu_control()       : ALU control decoder (ALUOp + funct fields -> ALU op)
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BEQ,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALUOp 01 is the branch compare and must yield subtract.
  // Only R-type (op[5]=1) with funct7[5]=1 turns funct3=000 into subtract;
  // I-type addi has no subtract form.
  function automatic logic [3:0] alu_control(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic       funct7_b5,
                                             input logic       op_b5);
    logic [3:0] ctl;
    ctl = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctl = (op_b5 && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctl = ALU_SLT;
          3'b110:  ctl = ALU_OR;
          3'b111:  ctl = ALU_AND;
          default: ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: counts consecutive cycles spent waiting for mem_ready
// while the controller sits in a memory-access state.
// Ports:
//   clk, reset : core clock, asynchronous active-high reset
//   active     : controller is in a state that waits on memory
//   mem_ready  : memory completed the access this cycle
//   timeout    : this is the MEM_WAIT_MAX-th waiting cycle and memory is
//                still not ready
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  // The count never needs to hold MEM_WAIT_MAX itself: the controller
  // leaves the waiting state on the cycle the count would reach it.
  localparam int unsigned CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] cnt;

  assign timeout = active && !mem_ready && (cnt == LIMIT);

  // Every exit from a waiting state happens on mem_ready (or timeout into
  // TRAP), so clearing on mem_ready or !active gives "cleared on entry" even
  // for the direct MEMWRITE -> FETCH hop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active || mem_ready) begin
      cnt <= '0;
    end else if (!timeout) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Ports:
//   clk, reset    : core clock, asynchronous active-high reset
//   opcode        : instr[6:0] from the instruction register
//   zero          : ALU zero flag (branch compare)
//   mem_ready     : shared memory completed the current access
//   pc_write, adr_src, mem_read, mem_write, ir_write, reg_write : enables
//   alu_src_a, alu_src_b, alu_op, result_src : datapath mux selects
//   trap          : sticky; illegal opcode or memory timeout
//   instret       : retired-instruction count (wraps)
module multicycle_control
  import core_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_next;
  logic   wait_active;
  logic   timeout;
  logic   retire;
  logic   pc_update;
  logic   branch;

  assign wait_active = (state == S_FETCH) || (state == S_MEMREAD) ||
                       (state == S_MEMWRITE);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .active   (wait_active),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_next = S_DECODE;
        else if (timeout) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BEQ;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:  state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready)    state_next = S_MEMWB;
        else if (timeout) state_next = S_TRAP;
      end
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)    state_next = S_FETCH;
        else if (timeout) state_next = S_TRAP;
      end
      S_EXEC_R: state_next = S_ALUWB;
      S_EXEC_I: state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BEQ:    state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    trap       = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign pc_write = pc_update || (branch && zero);

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

endmodule
